// File: rtl/uart_host_tx.sv
// 8N1 UART transmitter for the host end of the CPU serial link.
// Bytes enter through a small circular FIFO and leave LSB-first at a fixed baud divisor.
module uart_host_tx #(
    parameter int unsigned BAUD_DIV   = 5208,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          overflow,
    output logic                          tx_done,
    output logic                          UART_TX_LINE
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [15:0]    BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [LW-1:0]  DEPTH_L   = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            line_q, line_d;
    logic            ovf_q, ovf_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            baud_wrap;

    // full is judged on the registered level, so a write while full is lost even if a pop coincides
    assign full      = (level_q == DEPTH_L);
    assign push      = wr_en && !full;
    assign baud_wrap = (baud_q == BAUD_LAST);

    assign level        = level_q;
    assign busy         = (state_q != IDLE);
    assign overflow     = ovf_q;
    assign tx_done      = (state_q == STOP) && baud_wrap;
    assign UART_TX_LINE = line_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = 3'd0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    baud_d  = 16'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d  = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_d = 16'd0;
                    // chain straight into the next start bit when more data is queued
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        bit_d   = 3'd0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = 16'd0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        line_d   = 1'b1;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end

        // line is registered from the next state so it changes cleanly on the clock edge
        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_d[0];
            default: line_d = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            line_q   <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            line_q   <= line_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // payload storage carries no reset; only the pointers and level define validity
    always_ff @(posedge sysclk) begin
        shift_q <= shift_d;
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_host_tx.sv
// Self-checking bench for uart_host_tx: directed scenarios plus random traffic,
// compared every cycle against a frame-level reference model and a line decoder.
module tb_uart_host_tx;

    localparam int BD = 4;
    localparam int FD = 4;
    localparam int FRAME = 10 * BD;
    localparam int HIST = 8192;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic [2:0] level;
    logic       busy;
    logic       overflow;
    logic       tx_done;
    logic       UART_TX_LINE;

    uart_host_tx #(
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (FD)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .level        (level),
        .busy         (busy),
        .overflow     (overflow),
        .tx_done      (tx_done),
        .UART_TX_LINE (UART_TX_LINE)
    );

    always #5 sysclk = ~sysclk;

    int n_assert = 0;
    int n_fail = 0;

    // reference model: FIFO contents, current frame byte and position within the 40-cycle frame
    byte unsigned mq[$];
    byte unsigned sent_q[$];
    bit           m_active = 1'b0;
    int           m_pos = 0;
    byte unsigned m_cur = 8'h00;
    bit           m_ovf = 1'b0;

    int   cyc = 0;
    int   done_seen = 0;
    logic line_hist [HIST];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_update(input logic r, input logic we, input logic [7:0] d);
        bit was_full;
        if (r) begin
            mq.delete();
            sent_q.delete();
            m_active = 1'b0;
            m_pos = 0;
            m_ovf = 1'b0;
        end else begin
            was_full = (mq.size() == FD);
            if (m_active) begin
                if (m_pos == FRAME - 1) begin
                    if (mq.size() > 0) begin
                        m_cur = mq.pop_front();
                        m_pos = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_pos++;
                end
            end else if (mq.size() > 0) begin
                m_cur = mq.pop_front();
                m_active = 1'b1;
                m_pos = 0;
            end
            if (we) begin
                if (was_full) begin
                    m_ovf = 1'b1;
                end else begin
                    mq.push_back(d);
                    sent_q.push_back(d);
                end
            end
        end
    endtask

    function automatic logic exp_line();
        if (!m_active)           return 1'b1;
        if (m_pos < BD)          return 1'b0;
        if (m_pos < 9 * BD)      return m_cur[3'((m_pos - BD) / BD)];
        return 1'b1;
    endfunction

    task automatic check_outputs();
        logic [7:0] dec;
        line_hist[cyc % HIST] = UART_TX_LINE;
        chk("line",     32'(UART_TX_LINE), 32'(exp_line()));
        chk("busy",     32'(busy),         32'(m_active));
        chk("level",    32'(level),        32'(mq.size()));
        chk("full",     32'(full),         32'(mq.size() == FD));
        chk("overflow", 32'(overflow),     32'(m_ovf));
        chk("tx_done",  32'(tx_done),      32'(m_active && (m_pos == FRAME - 1)));
        if (tx_done === 1'b1) begin
            done_seen++;
            for (int b = 0; b < 8; b++) begin
                dec[b] = line_hist[(cyc - (FRAME - 1) + BD + BD * b + BD / 2) % HIST];
            end
            chk("rx_pending", 32'(sent_q.size() > 0), 32'd1);
            if (sent_q.size() > 0) begin
                chk("rx_byte", 32'(dec), 32'(sent_q.pop_front()));
            end
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [7:0] d);
        reset = r;
        wr_en = we;
        wr_data = d;
        @(posedge sysclk);
        cyc++;
        model_update(r, we, d);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int c0;
        int d0;
        logic [7:0] pat;

        // reset held 3 cycles, with a write attempt that must be ignored
        d0 = done_seen;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h77);
        step(1'b1, 1'b0, 8'h00);
        chk("rst_line",  32'(UART_TX_LINE), 32'd1);
        chk("rst_level", 32'(level),        32'd0);
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_ovf",   32'(overflow),     32'd0);
        idle(2);
        chk("rst_no_done", 32'(done_seen - d0), 32'd0);

        // single byte 0xA5
        d0 = done_seen;
        pat = 8'hA5;
        step(1'b0, 1'b1, pat);
        c0 = cyc;
        chk("single_level", 32'(level), 32'd1);
        idle(FRAME + 6);
        chk("single_start", 32'(line_hist[(c0 + 1) % HIST]), 32'd0);
        chk("single_start_end", 32'(line_hist[(c0 + 4) % HIST]), 32'd0);
        for (int b = 0; b < 8; b++) begin
            chk("single_bit", 32'(line_hist[(c0 + 5 + BD * b) % HIST]), 32'(pat[b]));
        end
        chk("single_stop", 32'(line_hist[(c0 + 37) % HIST]), 32'd1);
        chk("single_done", 32'(done_seen - d0), 32'd1);
        chk("single_idle", 32'(busy), 32'd0);

        // back-to-back 0x00, 0xFF
        d0 = done_seen;
        step(1'b0, 1'b1, 8'h00);
        c0 = cyc;
        step(1'b0, 1'b1, 8'hFF);
        idle(2 * FRAME + 6);
        chk("b2b_stop",       32'(line_hist[(c0 + FRAME) % HIST]), 32'd1);
        chk("b2b_next_start", 32'(line_hist[(c0 + FRAME + 1) % HIST]), 32'd0);
        chk("b2b_done",       32'(done_seen - d0), 32'd2);

        // overflow: six writes while idle, sixth dropped
        d0 = done_seen;
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 8'(i));
        chk("ovf_set",   32'(overflow), 32'd1);
        chk("ovf_level", 32'(level),    32'd4);
        idle(5 * FRAME + 6);
        chk("ovf_done",   32'(done_seen - d0), 32'd5);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // reset in the middle of data bit 3
        d0 = done_seen;
        step(1'b0, 1'b1, 8'h3C);
        c0 = cyc;
        idle(18);
        step(1'b1, 1'b0, 8'h00);
        chk("midrst_line",  32'(UART_TX_LINE), 32'd1);
        chk("midrst_level", 32'(level),        32'd0);
        chk("midrst_busy",  32'(busy),         32'd0);
        step(1'b0, 1'b1, 8'h81);
        idle(FRAME + 6);
        chk("midrst_done", 32'(done_seen - d0), 32'd1);

        // wrap-around: 10 random bytes in bursts of 3 with idle gaps
        d0 = done_seen;
        for (int burst = 0; burst < 4; burst++) begin
            for (int k = 0; k < 3 && burst * 3 + k < 10; k++) begin
                step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
            end
            idle(3 * FRAME + 10);
        end
        chk("wrap_done", 32'(done_seen - d0), 32'd10);
        chk("wrap_drained", 32'(sent_q.size()), 32'd0);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 11) == 0),
                 8'($urandom_range(0, 255)));
        end
        idle(5 * FRAME + 6);
        chk("final_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
